// File: rtl/light_phase_timer.sv
// Phase sequencer for the traffic light: drives the shared comparator with val/comp_with and
// cross-checks its result. Optional pedestrian WALK phase is built with `define PED_REQ_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RED    | red lamp, counting RED_TIME+1 cycles
// ST_GREEN  | green lamp, counting GREEN_TIME+1 cycles
// ST_YELLOW | yellow lamp, counting YELLOW_TIME+1 cycles
// ST_WALK   | red lamp plus walk, counting WALK_TIME+1 cycles (PED_REQ_EN)
// ST_FAULT  | comparator disagreed with internal compare; blink yellow until rst
module light_phase_timer #(
    parameter int unsigned RED_TIME    = 4,
    parameter int unsigned GREEN_TIME  = 5,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned WALK_TIME   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       comp,
`ifdef PED_REQ_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] val,
    output logic [2:0] comp_with,
    output logic [2:0] light,
    output logic       phase_done,
    output logic       err
);

    if (RED_TIME > 7 || GREEN_TIME > 7 || YELLOW_TIME > 7 || WALK_TIME > 7) begin : g_param_check
        $error("light_phase_timer: phase times must be in 0..7");
    end

    localparam logic [2:0] T_RED    = 3'(RED_TIME);
    localparam logic [2:0] T_GREEN  = 3'(GREEN_TIME);
    localparam logic [2:0] T_YELLOW = 3'(YELLOW_TIME);
`ifdef PED_REQ_EN
    localparam logic [2:0] T_WALK   = 3'(WALK_TIME);
`endif

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    typedef enum logic [2:0] {
        ST_RED    = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_FAULT  = 3'd3
`ifdef PED_REQ_EN
        ,
        ST_WALK   = 3'd4
`endif
    } state_t;

    state_t state;
    logic   eq;
    logic   mismatch;

    assign eq         = (val == comp_with);
    assign mismatch   = (eq != comp) && (state != ST_FAULT);
    assign phase_done = comp && (state != ST_FAULT);

`ifdef PED_REQ_EN
    logic ped_latch;
    logic go_walk;

    // A request in the final RED cycle is taken directly, without passing through the latch.
    assign go_walk = (state == ST_RED) && comp && !mismatch && (ped_latch || ped_req);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RED;
            val       <= 3'd0;
            comp_with <= T_RED;
            light     <= LIGHT_RED;
            err       <= 1'b0;
`ifdef PED_REQ_EN
            walk      <= 1'b0;
            ped_latch <= 1'b0;
`endif
        end else begin
`ifdef PED_REQ_EN
            if (go_walk) begin
                ped_latch <= 1'b0;
            end else if (ped_req) begin
                ped_latch <= 1'b1;
            end
`endif
            if (state == ST_FAULT) begin
                light <= (light == LIGHT_YELLOW) ? LIGHT_OFF : LIGHT_YELLOW;
            end else if (mismatch) begin
                // val and comp_with freeze at the values that exposed the fault
                state <= ST_FAULT;
                err   <= 1'b1;
                light <= LIGHT_YELLOW;
`ifdef PED_REQ_EN
                walk  <= 1'b0;
`endif
            end else if (comp) begin
                val <= 3'd0;
                case (state)
                    ST_RED: begin
`ifdef PED_REQ_EN
                        if (go_walk) begin
                            state     <= ST_WALK;
                            comp_with <= T_WALK;
                            light     <= LIGHT_RED;
                            walk      <= 1'b1;
                        end else begin
                            state     <= ST_GREEN;
                            comp_with <= T_GREEN;
                            light     <= LIGHT_GREEN;
                        end
`else
                        state     <= ST_GREEN;
                        comp_with <= T_GREEN;
                        light     <= LIGHT_GREEN;
`endif
                    end
                    ST_GREEN: begin
                        state     <= ST_YELLOW;
                        comp_with <= T_YELLOW;
                        light     <= LIGHT_YELLOW;
                    end
                    ST_YELLOW: begin
                        state     <= ST_RED;
                        comp_with <= T_RED;
                        light     <= LIGHT_RED;
                    end
`ifdef PED_REQ_EN
                    ST_WALK: begin
                        state     <= ST_GREEN;
                        comp_with <= T_GREEN;
                        light     <= LIGHT_GREEN;
                        walk      <= 1'b0;
                    end
`endif
                    default: begin
                        state <= ST_FAULT;
                        err   <= 1'b1;
                        light <= LIGHT_YELLOW;
                    end
                endcase
            end else begin
                val <= val + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_light_phase_timer.sv
// Self-checking bench for light_phase_timer: directed scenarios plus randomized fault
// injection, checked against a phase-list reference model.
module tb_light_phase_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       flip  = 1'b0;
    logic       stuck = 1'b0;
    logic       ped   = 1'b0;
    logic       sel_z = 1'b0;

    logic [2:0] d_val, d_cw, d_light, z_val, z_cw, z_light;
    logic       d_pd, d_err, z_pd, z_err, d_walk, z_walk;
    logic       d_comp, z_comp;

    // Behavioural comparator with fault injection (single-cycle flip or stuck-low)
    assign d_comp = stuck ? 1'b0 : ((d_val == d_cw) ^ flip);
    assign z_comp = stuck ? 1'b0 : ((z_val == z_cw) ^ flip);

    light_phase_timer dut (
        .clk        (clk),
        .rst        (rst),
        .comp       (d_comp),
`ifdef PED_REQ_EN
        .ped_req    (ped),
        .walk       (d_walk),
`endif
        .val        (d_val),
        .comp_with  (d_cw),
        .light      (d_light),
        .phase_done (d_pd),
        .err        (d_err)
    );

    light_phase_timer #(.YELLOW_TIME(0)) dut_z (
        .clk        (clk),
        .rst        (rst),
        .comp       (z_comp),
`ifdef PED_REQ_EN
        .ped_req    (ped),
        .walk       (z_walk),
`endif
        .val        (z_val),
        .comp_with  (z_cw),
        .light      (z_light),
        .phase_done (z_pd),
        .err        (z_err)
    );

`ifndef PED_REQ_EN
    assign d_walk = 1'b0;
    assign z_walk = 1'b0;
`endif

    logic [2:0] o_val, o_cw, o_light;
    logic       o_pd, o_err, o_walk;

    always_comb begin
        o_val   = sel_z ? z_val   : d_val;
        o_cw    = sel_z ? z_cw    : d_cw;
        o_light = sel_z ? z_light : d_light;
        o_pd    = sel_z ? z_pd    : d_pd;
        o_err   = sel_z ? z_err   : d_err;
        o_walk  = sel_z ? z_walk  : d_walk;
    end

    typedef struct packed {
        logic [2:0] light;
        logic [2:0] val;
        logic [2:0] cw;
        logic       pd;
        logic       walk;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a phase is TIME+1 cycles, val runs 0..TIME, done on the last one.
    // Phase codes: 0 RED, 1 GREEN, 2 YELLOW, 3 WALK.
    task automatic add_phase(input int ph, input int tm);
        exp_t e;
        for (int v = 0; v <= tm; v++) begin
            case (ph)
                1:       e.light = 3'b001;
                2:       e.light = 3'b010;
                default: e.light = 3'b100;
            endcase
            e.val  = 3'(v);
            e.cw   = 3'(tm);
            e.pd   = (v == tm);
            e.walk = (ph == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic build_normal(input int rt, input int gt, input int yt, input int periods);
        exp_q.delete();
        for (int p = 0; p < periods; p++) begin
            add_phase(0, rt);
            add_phase(1, gt);
            add_phase(2, yt);
        end
    endtask

    // Leaves the bench 1 time unit after the edge that produced the reset state (cycle 0).
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; flip = 1'b0; stuck = 1'b0; ped = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // mode 0: clean comparator; 1: comp inverted in cycle tf_in; 2: comp stuck low.
    task automatic run_check(input string name, input int n, input int mode, input int tf_in,
                             input int p1, input int p2);
        int   tf;
        exp_t e;
        logic [2:0] e_light, e_val;
        logic e_pd, e_err, e_walk;
        tf = (mode == 1) ? tf_in : -1;
        if (mode == 2) begin
            for (int k = 0; k < exp_q.size(); k++) begin
                if (tf < 0 && exp_q[k].pd) tf = k;
            end
            stuck = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            flip = (mode == 1 && i == tf);
            ped  = (i == p1 || i == p2);
            @(negedge clk);
            e       = exp_q[i];
            e_light = e.light;
            e_val   = e.val;
            e_pd    = e.pd;
            e_walk  = e.walk;
            e_err   = 1'b0;
            if (tf >= 0 && i == tf) begin
                e_pd = ~exp_q[tf].pd;
            end else if (tf >= 0 && i > tf) begin
                e_light = ((i - tf) % 2 == 1) ? 3'b010 : 3'b000;
                e_val   = exp_q[tf].val;
                e_pd    = 1'b0;
                e_walk  = 1'b0;
                e_err   = 1'b1;
            end
            n_cmp++;
            if (o_light !== e_light) begin
                n_bad++;
                $display("FAIL %s light cyc %0d: got %b want %b", name, i, o_light, e_light);
            end
            n_cmp++;
            if (o_val !== e_val) begin
                n_bad++;
                $display("FAIL %s val cyc %0d: got %0d want %0d", name, i, o_val, e_val);
            end
            n_cmp++;
            if (o_pd !== e_pd) begin
                n_bad++;
                $display("FAIL %s phase_done cyc %0d: got %b want %b", name, i, o_pd, e_pd);
            end
            n_cmp++;
            if (o_err !== e_err) begin
                n_bad++;
                $display("FAIL %s err cyc %0d: got %b want %b", name, i, o_err, e_err);
            end
            n_cmp++;
            if (o_walk !== e_walk) begin
                n_bad++;
                $display("FAIL %s walk cyc %0d: got %b want %b", name, i, o_walk, e_walk);
            end
            if (tf < 0 || i <= tf) begin
                n_cmp++;
                if (o_cw !== e.cw) begin
                    n_bad++;
                    $display("FAIL %s comp_with cyc %0d: got %0d want %0d", name, i, o_cw, e.cw);
                end
            end
            @(posedge clk);
            #1;
        end
        flip = 1'b0; ped = 1'b0; stuck = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        @(negedge clk);
        n_cmp++;
        if (o_light !== 3'b100) begin
            n_bad++; $display("FAIL %s light: got %b want 100", name, o_light);
        end
        n_cmp++;
        if (o_val !== 3'd0) begin
            n_bad++; $display("FAIL %s val: got %0d want 0", name, o_val);
        end
        n_cmp++;
        if (o_cw !== 3'd4) begin
            n_bad++; $display("FAIL %s comp_with: got %0d want 4", name, o_cw);
        end
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_bad++; $display("FAIL %s err: got %b want 0", name, o_err);
        end
        n_cmp++;
        if (o_pd !== 1'b0) begin
            n_bad++; $display("FAIL %s phase_done: got %b want 0", name, o_pd);
        end
        n_cmp++;
        if (o_walk !== 1'b0) begin
            n_bad++; $display("FAIL %s walk: got %b want 0", name, o_walk);
        end
    endtask

    task automatic test_reset();
        sel_z = 1'b0;
        do_reset();
        check_reset_state("reset");
    endtask

    task automatic test_normal();
        sel_z = 1'b0;
        build_normal(4, 5, 2, 3);
        do_reset();
        run_check("normal", 42, 0, -1, -1, -1);
    endtask

    task automatic test_zero_len();
        sel_z = 1'b1;
        build_normal(4, 5, 0, 4);
        do_reset();
        run_check("zero_len", 40, 0, -1, -1, -1);
        sel_z = 1'b0;
    endtask

    task automatic test_stuck_low();
        sel_z = 1'b0;
        build_normal(4, 5, 2, 2);
        do_reset();
        run_check("stuck_low", 12, 2, -1, -1, -1);
        do_reset();
        check_reset_state("stuck_low_rst");
    endtask

    task automatic test_reset_mid();
        sel_z = 1'b0;
        build_normal(4, 5, 2, 2);
        do_reset();
        run_check("reset_mid", 8, 0, -1, -1, -1);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_light !== 3'b001 || o_val !== 3'd3) begin
            n_bad++;
            $display("FAIL reset_mid pre: got light %b val %0d want 001/3", o_light, o_val);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset_mid_post");
    endtask

    task automatic test_random();
        int n, mode, tf;
        for (int it = 0; it < 30; it++) begin
            sel_z = 1'($urandom_range(0, 1));
            build_normal(4, 5, sel_z ? 0 : 2, 5);
            n    = $urandom_range(8, 50);
            mode = $urandom_range(0, 2);
            tf   = $urandom_range(0, n - 1);
            do_reset();
            run_check("random", n, mode, tf, -1, -1);
        end
        sel_z = 1'b0;
    endtask

`ifdef PED_REQ_EN
    task automatic test_ped();
        sel_z = 1'b0;
        exp_q.delete();
        add_phase(0, 4); add_phase(1, 5); add_phase(2, 2);
        add_phase(0, 4); add_phase(3, 3); add_phase(1, 5); add_phase(2, 2);
        add_phase(0, 4); add_phase(1, 5); add_phase(2, 2);
        add_phase(0, 4); add_phase(3, 3); add_phase(1, 5);
        do_reset();
        // cycle 7 is mid-GREEN; cycle 50 is the final cycle of the fourth RED
        run_check("ped", 61, 0, -1, 7, 50);
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_zero_len();
        test_stuck_low();
        test_reset_mid();
`ifdef PED_REQ_EN
        test_ped();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/light_phase_timer.md
# light_phase_timer

Phase sequencer for the traffic-light controller. It drives the shared 3-bit comparator with a running count (`val`) and the current phase duration (`comp_with`). It consumes the comparator's equality result (`comp`) to advance RED → GREEN → YELLOW → RED. It also cross-checks `comp` against its own internal compare and latches a fault when the two disagree.

## Interface

**Parameters**
- `RED_TIME`, default 4: RED phase terminal count, 0–7.
- `GREEN_TIME`, default 5: GREEN phase terminal count, 0–7.
- `YELLOW_TIME`, default 2: YELLOW phase terminal count, 0–7.
- `WALK_TIME`, default 3: WALK phase terminal count, 0–7. Used only with `PED_REQ_EN`.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `comp`, input, 1: comparator result; 1 when `val == comp_with`.
- `val`, output, 3: phase cycle counter, fed to the comparator.
- `comp_with`, output, 3: terminal count of the current phase, fed to the comparator.
- `light`, output, 3: one-hot `{red, yellow, green}`.
- `phase_done`, output, 1: one-cycle pulse in the last cycle of a phase.
- `err`, output, 1: sticky comparator-mismatch fault.
- `ped_req`, input, 1: pedestrian request. Present only with `PED_REQ_EN`.
- `walk`, output, 1: walk indicator. Present only with `PED_REQ_EN`.

## Operation

**States:** RED, GREEN, YELLOW, FAULT, plus WALK with `PED_REQ_EN`. State encoding is implementation choice.

**Reset values**
- State RED.
- `val` = 0.
- `comp_with` = RED_TIME.
- `light` = 3'b100.
- `phase_done` = 0, `err` = 0, `walk` = 0.
- Pedestrian latch cleared.

**Counting**
- `val` increments by 1 each cycle while `comp` = 0.
- On a cycle with `comp` = 1: `val` ← 0, state advances, and `comp_with` ← terminal count of the next state.
- Each phase lasts TIME+1 cycles. TIME = 0 gives a one-cycle phase.

**Transitions (on `comp` = 1)**
- RED → GREEN, or RED → WALK if the pedestrian latch is set (`PED_REQ_EN`).
- GREEN → YELLOW.
- YELLOW → RED.
- WALK → GREEN. The pedestrian latch clears on WALK entry.

**Outputs per state**
- `light`: RED = 100, GREEN = 001, YELLOW = 010, WALK = 100.
- `walk` = 1 only in WALK.

**Registering**
- `light`, `walk` and `comp_with` are registered and change in the same edge as the state.
- `phase_done` is combinational: `comp` AND (state ≠ FAULT).

**Cross-check**
- Each cycle, the internal `eq = (val == comp_with)` is compared against `comp`.
- Any mismatch outside FAULT → next edge: state FAULT, `err` ← 1.
- In FAULT:
  - `val` holds.
  - `light` toggles between 010 and 000 every cycle, starting at 010.
  - `walk` = 0, `phase_done` = 0.
  - `comp` is ignored.
- FAULT is exited only by `rst`.

**Wrap-around:** `val` never wraps under a correct comparator, because the terminal count is ≤ 7. If `val` reaches 7 with `comp` = 0 and `comp_with` = 7, that is a mismatch and gives FAULT.

**Priority:** `rst` overrides everything, including mid-phase and FAULT. The next cycle is the reset state.

## Timing

- Comparator is combinational: `comp` is valid in the same cycle as `val` / `comp_with`.
- First transition after reset deassert: RED lasts RED_TIME+1 cycles, then `light` = 001 in the following cycle.
- Full cycle period without WALK = RED_TIME + GREEN_TIME + YELLOW_TIME + 3 cycles.
- Fault detection latency: `err` / FAULT asserted 1 edge after the first mismatching cycle.

**Pedestrian latch (`PED_REQ_EN`)**
- Set on any cycle with `ped_req` = 1, except when the RED→WALK transition occurs that same edge.
- `ped_req` = 1 in the final RED cycle (the cycle with `comp` = 1) is honoured immediately.

## Configuration

- **With `PED_REQ_EN` defined:**
  - `ped_req` and `walk` ports exist.
  - Pedestrian latch and WALK state exist.
  - `WALK_TIME` is used.
- **Without it:**
  - No `ped_req`/`walk` ports and no latch.
  - The state machine is RED/GREEN/YELLOW/FAULT only.
  - `WALK_TIME` is ignored.

## Test plan

All scenarios use default parameters and a behavioural comparator unless noted.

1. **Reset.** Hold `rst` for 2 cycles. → `light` = 100, `val` = 0, `comp_with` = 4, `err` = 0, `phase_done` = 0.
2. **Normal sequence.** Run 16 cycles. → RED for 5 cycles, GREEN for 6, YELLOW for 3, then RED. `phase_done` pulses on cycles 5, 11 and 14. `comp_with` sequence is 4, 5, 2, 4.
3. **Zero-length phase.** Set YELLOW_TIME = 0. → YELLOW lasts exactly 1 cycle, `light` = 010 for one cycle. Total period = 12.
4. **Stuck-low comparator.** Force `comp` = 0. → mismatch when `val` = 4 in RED. Next edge: `err` = 1, `light` = 010, then 000, then 010… `val` holds at 4. Assert `rst` → normal reset state.
5. **Reset mid-phase.** Assert `rst` when GREEN has `val` = 3. → next edge: RED, `val` = 0, `comp_with` = 4.
6. **Pedestrian request (`PED_REQ_EN`).** Pulse `ped_req` for 1 cycle during GREEN. → after the next RED, WALK for 4 cycles with `walk` = 1 and `light` = 100, then GREEN. A second RED with no request goes straight to GREEN.
